// File: rtl/tile_link_if.sv
// One side of a tile-to-link connection: the tile drives send/recv requests,
// and the link returns the received word, its valid flag and the send-done pulse.
interface tile_link_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] send_data;
    logic              send_ready;
    logic              recv_ready;
    logic [WORD_W-1:0] recv_data;
    logic              recv_valid;
    logic              send_done;

    modport master (
        output send_data, send_ready, recv_ready,
        input  recv_data, recv_valid, send_done
    );

    modport slave (
        input  send_data, send_ready, recv_ready,
        output recv_data, recv_valid, send_done
    );
endinterface

// File: rtl/tile_link.sv
// Point-to-point rendezvous channel between two adjacent tiles.
// Each direction has its own single-word buffer, a three-state FSM and a transfer counter.
module tile_link #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    tile_link_if.slave       a_if,
    tile_link_if.slave       b_if,
    output logic [CNT_W-1:0] xfer_cnt_ab_o,
    output logic [CNT_W-1:0] xfer_cnt_ba_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FULL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Index 0 is the A->B direction, index 1 is B->A.
    logic [1:0][WORD_W-1:0] snd_data;
    logic [1:0]             snd_rdy;
    logic [1:0]             rcv_rdy;
    logic [1:0][WORD_W-1:0] rx_data;
    logic [1:0]             rx_valid;
    logic [1:0]             tx_done;
    logic [1:0][CNT_W-1:0]  cnt;

    assign snd_data[0] = a_if.send_data;
    assign snd_rdy[0]  = a_if.send_ready;
    assign rcv_rdy[0]  = b_if.recv_ready;
    assign snd_data[1] = b_if.send_data;
    assign snd_rdy[1]  = b_if.send_ready;
    assign rcv_rdy[1]  = a_if.recv_ready;

    assign b_if.recv_data  = rx_data[0];
    assign b_if.recv_valid = rx_valid[0];
    assign a_if.send_done  = tx_done[0];
    assign a_if.recv_data  = rx_data[1];
    assign a_if.recv_valid = rx_valid[1];
    assign b_if.send_done  = tx_done[1];

    assign xfer_cnt_ab_o = cnt[0];
    assign xfer_cnt_ba_o = cnt[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dir
            logic [1:0]        state_q, state_d;
            logic [WORD_W-1:0] buf_q, buf_d;
            logic [CNT_W-1:0]  cnt_q, cnt_d;

            always_comb begin
                state_d = state_q;
                buf_d   = buf_q;
                cnt_d   = cnt_q;
                case (state_q)
                    ST_IDLE: begin
                        if (snd_rdy[gi]) begin
                            buf_d   = snd_data[gi];
                            state_d = ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        // A consume in the same cycle as a withdraw still completes.
                        if (rcv_rdy[gi]) begin
                            state_d = ST_DONE;
                            cnt_d   = cnt_q + 1'b1;
                        end else if (!snd_rdy[gi]) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= ST_IDLE;
                    buf_q   <= '0;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    buf_q   <= buf_d;
                    cnt_q   <= cnt_d;
                end
            end

            // Outputs depend only on registers, so reset clears them immediately.
            assign rx_valid[gi] = (state_q == ST_FULL);
            assign rx_data[gi]  = (state_q == ST_FULL) ? buf_q : '0;
            assign tx_done[gi]  = (state_q == ST_DONE);
            assign cnt[gi]      = cnt_q;
        end
    endgenerate
endmodule

// File: tb/tb_tile_link.sv
// Directed bench for tile_link: expected words are queued when sent and
// compared when the receiving side consumes them.
module tb_tile_link;
    logic        clk;
    logic        rst;
    logic [7:0]  cnt_ab;
    logic [7:0]  cnt_ba;
    int          errors;
    int          checks;
    logic [15:0] exp_ab[$];
    logic [15:0] exp_ba[$];

    tile_link_if #(.WORD_W(16)) a_if ();
    tile_link_if #(.WORD_W(16)) b_if ();

    tile_link #(.WORD_W(16), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .a_if          (a_if.slave),
        .b_if          (b_if.slave),
        .xfer_cnt_ab_o (cnt_ab),
        .xfer_cnt_ba_o (cnt_ba)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic consume_ab(input string tag);
        logic [15:0] w;
        if (exp_ab.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: observed empty scoreboard expected a queued word", tag);
        end else begin
            w = exp_ab.pop_front();
            chk(tag, {31'd0, b_if.recv_valid}, 32'd1);
            chk(tag, {16'd0, b_if.recv_data}, {16'd0, w});
        end
    endtask

    task automatic consume_ba(input string tag);
        logic [15:0] w;
        if (exp_ba.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: observed empty scoreboard expected a queued word", tag);
        end else begin
            w = exp_ba.pop_front();
            chk(tag, {31'd0, a_if.recv_valid}, 32'd1);
            chk(tag, {16'd0, a_if.recv_data}, {16'd0, w});
        end
    endtask

    initial begin
        logic [15:0] w;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        a_if.send_data = '0; a_if.send_ready = 1'b0; a_if.recv_ready = 1'b0;
        b_if.send_data = '0; b_if.send_ready = 1'b0; b_if.recv_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_b_valid", {31'd0, b_if.recv_valid}, 32'd0);
        chk("rst_a_valid", {31'd0, a_if.recv_valid}, 32'd0);
        chk("rst_a_done",  {31'd0, a_if.send_done}, 32'd0);
        chk("rst_b_done",  {31'd0, b_if.send_done}, 32'd0);
        chk("rst_b_data",  {16'd0, b_if.recv_data}, 32'd0);
        chk("rst_cnt_ab",  {24'd0, cnt_ab}, 32'd0);
        chk("rst_cnt_ba",  {24'd0, cnt_ba}, 32'd0);

        // Basic transfer
        a_if.send_data = 16'h0123; a_if.send_ready = 1'b1; exp_ab.push_back(16'h0123);
        step();
        $display("basic: send 0123");
        consume_ab("basic_data");
        chk("basic_nodone", {31'd0, a_if.send_done}, 32'd0);
        b_if.recv_ready = 1'b1;
        step();
        chk("basic_done",   {31'd0, a_if.send_done}, 32'd1);
        chk("basic_vld0",   {31'd0, b_if.recv_valid}, 32'd0);
        chk("basic_data0",  {16'd0, b_if.recv_data}, 32'd0);
        chk("basic_cnt",    {24'd0, cnt_ab}, 32'd1);
        a_if.send_ready = 1'b0; b_if.recv_ready = 1'b0;
        step();
        chk("basic_done1",  {31'd0, a_if.send_done}, 32'd0);
        chk("basic_idle",   {31'd0, b_if.recv_valid}, 32'd0);

        // Blocking receiver
        a_if.send_data = 16'hFC19; a_if.send_ready = 1'b1; exp_ab.push_back(16'hFC19);
        step();
        $display("block: send FC19, receiver stalled 10 cycles");
        a_if.send_data = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            chk("block_vld",  {31'd0, b_if.recv_valid}, 32'd1);
            chk("block_data", {16'd0, b_if.recv_data}, {16'd0, exp_ab[0]});
            chk("block_nodone", {31'd0, a_if.send_done}, 32'd0);
            step();
        end
        b_if.recv_ready = 1'b1;
        consume_ab("block_consume");
        step();
        chk("block_done", {31'd0, a_if.send_done}, 32'd1);
        chk("block_cnt",  {24'd0, cnt_ab}, 32'd2);
        a_if.send_ready = 1'b0; b_if.recv_ready = 1'b0;
        step();
        chk("block_done1", {31'd0, a_if.send_done}, 32'd0);

        // Withdraw without consumer
        a_if.send_data = 16'h1111; a_if.send_ready = 1'b1; exp_ab.push_back(16'h1111);
        step();
        $display("withdraw: send 1111 then drop send_ready");
        chk("wd_vld", {31'd0, b_if.recv_valid}, 32'd1);
        a_if.send_ready = 1'b0;
        step();
        w = exp_ab.pop_front();
        chk("wd_vld0",   {31'd0, b_if.recv_valid}, 32'd0);
        chk("wd_data0",  {16'd0, b_if.recv_data}, 32'd0);
        chk("wd_nodone", {31'd0, a_if.send_done}, 32'd0);
        chk("wd_cnt",    {24'd0, cnt_ab}, 32'd2);
        step();
        chk("wd_nodone2", {31'd0, a_if.send_done}, 32'd0);

        // Withdraw and consume in the same cycle: consume wins
        a_if.send_data = 16'h2222; a_if.send_ready = 1'b1; exp_ab.push_back(16'h2222);
        step();
        $display("withdraw+consume: send 2222");
        a_if.send_ready = 1'b0; b_if.recv_ready = 1'b1;
        consume_ab("wc_consume");
        step();
        chk("wc_done", {31'd0, a_if.send_done}, 32'd1);
        chk("wc_cnt",  {24'd0, cnt_ab}, 32'd3);
        b_if.recv_ready = 1'b0;
        step();

        // Bidirectional
        a_if.send_data = 16'h0007; a_if.send_ready = 1'b1; exp_ab.push_back(16'h0007);
        b_if.send_data = 16'h0009; b_if.send_ready = 1'b1; exp_ba.push_back(16'h0009);
        a_if.recv_ready = 1'b1; b_if.recv_ready = 1'b1;
        step();
        $display("bidir: A sends 0007, B sends 0009");
        consume_ab("bidir_ab");
        consume_ba("bidir_ba");
        a_if.send_ready = 1'b0; b_if.send_ready = 1'b0;
        step();
        chk("bidir_a_done", {31'd0, a_if.send_done}, 32'd1);
        chk("bidir_b_done", {31'd0, b_if.send_done}, 32'd1);
        chk("bidir_cnt_ab", {24'd0, cnt_ab}, 32'd4);
        chk("bidir_cnt_ba", {24'd0, cnt_ba}, 32'd1);
        a_if.recv_ready = 1'b0; b_if.recv_ready = 1'b0;
        step();

        // Asynchronous reset while A->B is FULL
        a_if.send_data = 16'hABCD; a_if.send_ready = 1'b1; exp_ab.push_back(16'hABCD);
        step();
        $display("async reset: ABCD buffered, reset mid-cycle");
        chk("ar_full", {31'd0, b_if.recv_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        w = exp_ab.pop_front();
        chk("ar_vld",    {31'd0, b_if.recv_valid}, 32'd0);
        chk("ar_data",   {16'd0, b_if.recv_data}, 32'd0);
        chk("ar_done",   {31'd0, a_if.send_done}, 32'd0);
        chk("ar_cnt_ab", {24'd0, cnt_ab}, 32'd0);
        chk("ar_cnt_ba", {24'd0, cnt_ba}, 32'd0);
        a_if.send_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ar_post_done", {31'd0, a_if.send_done}, 32'd0);
            chk("ar_post_vld",  {31'd0, b_if.recv_valid}, 32'd0);
        end

        // Counter wrap over 256 back-to-back transfers
        b_if.recv_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = 16'(i * 257);
            a_if.send_data = w; a_if.send_ready = 1'b1; exp_ab.push_back(w);
            step();
            consume_ab("wrap_data");
            step();
            chk("wrap_done", {31'd0, a_if.send_done}, 32'd1);
            chk("wrap_cnt",  {24'd0, cnt_ab}, 32'((i + 1) % 256));
            step();
        end
        a_if.send_ready = 1'b0; b_if.recv_ready = 1'b0;
        step();
        $display("wrap: 256 transfers done");
        chk("wrap_cnt_ab", {24'd0, cnt_ab}, 32'd0);
        chk("wrap_cnt_ba", {24'd0, cnt_ba}, 32'd0);
        chk("wrap_idle",   {31'd0, b_if.recv_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
